spi_sensor_responder: RTL and testbench
=======================================

# spi_sensor_responder

SPI peripheral (responder) that plays the light-sensor end of the sensor SPI link: it answers chip-select/SCLK from the design's SPI master with a 16-bit ADC-style frame carrying an 8-bit light sample, and captures the MOSI bits clocked in during the same frame. It sits on the far side of the SPI pins (`o_SPI_Clk`, `o_SPI_MOSI`, `C_Select` → its inputs; its MISO → master `i_SPI_MISO`). It serves as a synthesizable sensor stand-in for closed-loop system tests and as a bench responder. SPI mode 0 is used, oversampled by the system clock.

## Interface
- `LEAD_ZEROS`, default 3: zero bits sent before the sample MSB.
- `DATA_W`, default 8: sample width.
- `FRAME_W`, default 16: SCLK rising edges per complete frame. The constraint LEAD_ZEROS + DATA_W ≤ FRAME_W applies.

Ports:
- `i_clk`  in  1  system clock. This is the single clock of the block.
- `rst`  in  1  reset, synchronous, active-high.
- `i_spi_clk`  in  1  SCLK from master, asynchronous to `i_clk`.
- `i_spi_mosi`  in  1  MOSI from master.
- `i_cs_n`  in  1  chip select, active low.
- `o_spi_miso`  out  1  MISO to master.
- `i_sample`  in  DATA_W  light sample to serve.
- `i_sample_valid`  in  1  loads `i_sample` into the held-sample register.
- `o_busy`  out  1  frame in progress.
- `o_rx_data`  out  FRAME_W  MOSI bits of the last complete frame, first bit received is the MSB.
- `o_rx_valid`  out  1  one-cycle pulse when `o_rx_data` updates.
- `o_abort`  out  1  one-cycle pulse when CS rises before FRAME_W rising edges.
- `o_frame_cnt`  out  8  count of complete frames; wraps 255→0.

## Operation
- Inputs `i_spi_clk`, `i_spi_mosi` and `i_cs_n` each pass through a 2-FF synchronizer. Edges are detected on the synchronized values against a delayed copy.
- State machine has three states: IDLE, ARMED, ACTIVE.
  - IDLE: entered from reset. Moves to ARMED when synchronized CS is high. CS edges are ignored in this state.
  - ARMED: a CS falling edge does the following:
    - loads the shift register with {LEAD_ZEROS zeros, held sample, zero fill};
    - clears the bit counter and `o_rx_data` shifter;
    - moves to ACTIVE.
  - ACTIVE:
    - On each SCLK rising edge: shift MOSI into the rx shifter LSB and increment the counter, saturating at FRAME_W.
    - On each SCLK falling edge: shift the tx register left, zero-filled.
    - `o_spi_miso` = tx register MSB.
  - CS rising edge in ACTIVE:
    - If counter == FRAME_W: latch the rx shifter into `o_rx_data`, pulse `o_rx_valid`, increment `o_frame_cnt`.
    - Otherwise: pulse `o_abort`; `o_rx_data` and `o_frame_cnt` are unchanged.
    - In both cases, move to ARMED.
- Edges beyond FRAME_W: MOSI is ignored, the counter stays saturated, and MISO shifts out zeros.
- Held sample:
  - `i_sample_valid` updates it in any state.
  - An update during ACTIVE does not affect the frame in flight.
  - If `i_sample_valid` is high on the same cycle as the CS falling edge, the frame carries the new `i_sample` (bypass).
- `o_spi_miso` = 0 outside ACTIVE.
- `o_busy` = (state == ACTIVE).
- Simultaneous SCLK edge and CS rise in the same cycle: CS takes priority and the SCLK edge is dropped.
- Reset values: all outputs 0. State = IDLE, held sample 0, counter 0, synchronizer stages 0. Reset mid-frame drops the frame with no `o_abort`. A frame can only start after CS has been seen high.

## Timing
- Any pin change affects internal logic 3 `i_clk` cycles later: 2 sync stages plus the edge register.
- MISO changes 1 cycle after the detected SCLK falling edge, or on the CS falling edge for the first bit.
- The master's SCLK high and low phases must each be ≥ 4 `i_clk` cycles. CS setup before the first SCLK rising edge must be ≥ 4 cycles.
- `o_rx_valid`, `o_abort` and the `o_frame_cnt` update occur in the cycle after the CS rising edge is detected. Each is exactly 1 cycle wide.

## Structure
- Package `spi_resp_pkg` holds:
  - the state enum (IDLE, ARMED, ACTIVE);
  - default FRAME_W, DATA_W, LEAD_ZEROS;
  - the counter width as $clog2(FRAME_W+1).
- Sub-module `sync_2ff`, a 1-bit synchronizer with synchronous reset, instantiated three times.
- Top `spi_sensor_responder` holds the FSM, shifters, counter and held-sample register.

## Test plan
- Reset, then `i_sample`=0xA5 with valid, then a 16-clock frame → MISO bits 000_10100101_00000, `o_rx_valid` pulse, `o_frame_cnt`=1.
- MOSI 0x3C7E across 16 clocks → `o_rx_data`=0x3C7E in the cycle after CS rises.
- CS rises after 9 clocks → `o_abort` pulse; `o_rx_valid` stays 0; `o_frame_cnt` and `o_rx_data` unchanged.
- `i_sample_valid` with 0xFF mid-frame while 0x12 is in flight → current frame carries 0x12 and the next frame carries 0xFF.
- 256 complete frames → `o_frame_cnt` wraps to 0. 20 clocks in one frame → bits 17-20 on MISO are 0, `o_rx_data` holds the first 16 MOSI bits, and the frame counts as complete.
- Reset asserted mid-frame with CS held low → no pulses after release. The next frame starts only after CS has gone high then low.

Source files
------------

// File: rtl/spi_sensor_responder_pkg.sv
// Shared types and default geometry for the SPI light-sensor responder.
package spi_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } resp_state_t;

    localparam int FRAME_W_DEF    = 16;
    localparam int DATA_W_DEF     = 8;
    localparam int LEAD_ZEROS_DEF = 3;
    localparam int CNT_W_DEF      = $clog2(FRAME_W_DEF + 1);

endpackage

// File: rtl/spi_sensor_responder_sync_2ff.sv
// Single-bit two-stage synchronizer for the SPI pins, cleared by synchronous reset.
module sync_2ff (
    input  logic i_clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge i_clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/spi_sensor_responder.sv
// Mode-0 SPI responder: serves a 16-bit frame carrying the held light sample on MISO
// and captures MOSI, oversampled on i_clk.
//
// state  | meaning
// IDLE   | after reset, waiting to see CS high
// ARMED  | CS high, next CS fall starts a frame
// ACTIVE | frame in progress, shifting on SCLK edges
module spi_sensor_responder
    import spi_resp_pkg::*;
#(
    parameter int LEAD_ZEROS = LEAD_ZEROS_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FRAME_W    = FRAME_W_DEF
) (
    input  logic               i_clk,
    input  logic               rst,
    input  logic               i_spi_clk,
    input  logic               i_spi_mosi,
    input  logic               i_cs_n,
    output logic               o_spi_miso,
    input  logic [DATA_W-1:0]  i_sample,
    input  logic               i_sample_valid,
    output logic               o_busy,
    output logic [FRAME_W-1:0] o_rx_data,
    output logic               o_rx_valid,
    output logic               o_abort,
    output logic [7:0]         o_frame_cnt
);

    localparam int CNT_W  = $clog2(FRAME_W + 1);
    localparam int FILL_W = FRAME_W - LEAD_ZEROS - DATA_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    logic sclk_s, mosi_s, cs_n_s;

    sync_2ff u_sync_sclk (.i_clk(i_clk), .rst(rst), .d_i(i_spi_clk),  .q_o(sclk_s));
    sync_2ff u_sync_mosi (.i_clk(i_clk), .rst(rst), .d_i(i_spi_mosi), .q_o(mosi_s));
    sync_2ff u_sync_cs   (.i_clk(i_clk), .rst(rst), .d_i(i_cs_n),     .q_o(cs_n_s));

    resp_state_t        state_q;
    logic               sclk_q, cs_n_q;
    logic [FRAME_W-1:0] tx_q, rx_q, rx_data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  held_q;
    logic               rx_valid_q, abort_q;
    logic [7:0]         frame_cnt_q;

    logic               sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [DATA_W-1:0]  sample_d;
    logic [FRAME_W-1:0] tx_load_d;

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_rise   = cs_n_s & ~cs_n_q;
    assign cs_fall   = ~cs_n_s & cs_n_q;

    // A sample arriving on the same cycle as the frame start goes straight into the frame.
    assign sample_d  = i_sample_valid ? i_sample : held_q;
    assign tx_load_d = FRAME_W'(sample_d) << FILL_W;

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            rx_data_q   <= '0;
            cnt_q       <= '0;
            held_q      <= '0;
            rx_valid_q  <= 1'b0;
            abort_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sclk_q     <= sclk_s;
            cs_n_q     <= cs_n_s;
            rx_valid_q <= 1'b0;
            abort_q    <= 1'b0;
            if (i_sample_valid) begin
                held_q <= i_sample;
            end
            case (state_q)
                IDLE: begin
                    if (cs_n_s) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (cs_fall) begin
                        tx_q    <= tx_load_d;
                        rx_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // CS release wins over any SCLK edge seen in the same cycle.
                    if (cs_rise) begin
                        if (cnt_q == CNT_FULL) begin
                            rx_data_q   <= rx_q;
                            rx_valid_q  <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else begin
                            abort_q <= 1'b1;
                        end
                        state_q <= ARMED;
                    end else begin
                        if (sclk_rise && (cnt_q != CNT_FULL)) begin
                            rx_q  <= {rx_q[FRAME_W-2:0], mosi_s};
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (sclk_fall) begin
                            tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_spi_miso  = (state_q == ACTIVE) & tx_q[FRAME_W-1];
    assign o_busy      = (state_q == ACTIVE);
    assign o_rx_data   = rx_data_q;
    assign o_rx_valid  = rx_valid_q;
    assign o_abort     = abort_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed bench for spi_sensor_responder: a mode-0 master drives frames, a scoreboard
// holds the expected {rx_data, frame_cnt} for each completed frame.
module tb_spi_sensor_responder;

    localparam int HALF = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  cnt;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_spi_clk = 1'b0;
    logic        i_spi_mosi = 1'b0;
    logic        i_cs_n = 1'b1;
    logic        o_spi_miso;
    logic [7:0]  i_sample = 8'h00;
    logic        i_sample_valid = 1'b0;
    logic        o_busy;
    logic [15:0] o_rx_data;
    logic        o_rx_valid;
    logic        o_abort;
    logic [7:0]  o_frame_cnt;

    int   total = 0;
    int   bad = 0;
    int   abort_seen = 0;
    int   exp_abort = 0;
    logic [7:0] exp_cnt = 8'd0;
    exp_t sb[$];
    logic prev_valid = 1'b0;
    logic prev_abort = 1'b0;

    spi_sensor_responder dut (
        .i_clk         (i_clk),
        .rst           (rst),
        .i_spi_clk     (i_spi_clk),
        .i_spi_mosi    (i_spi_mosi),
        .i_cs_n        (i_cs_n),
        .o_spi_miso    (o_spi_miso),
        .i_sample      (i_sample),
        .i_sample_valid(i_sample_valid),
        .o_busy        (o_busy),
        .o_rx_data     (o_rx_data),
        .o_rx_valid    (o_rx_valid),
        .o_abort       (o_abort),
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (!rst) begin
            if (o_rx_valid) begin
                exp_t e;
                total++;
                assert (sb.size() > 0) else begin
                    bad++;
                    $error("FAIL sb_unexpected_valid observed rx=%h cnt=%0d expected no pulse", o_rx_data, o_frame_cnt);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    total++;
                    assert ({o_rx_data, o_frame_cnt} === {e.data, e.cnt}) else begin
                        bad++;
                        $error("FAIL sb_rx observed rx=%h cnt=%0d expected rx=%h cnt=%0d", o_rx_data, o_frame_cnt, e.data, e.cnt);
                    end
                end
                total++;
                assert (!prev_valid) else begin
                    bad++;
                    $error("FAIL valid_width observed=2+ cycles expected=1 cycle");
                end
            end
            if (o_abort) begin
                abort_seen++;
                total++;
                assert (!prev_abort) else begin
                    bad++;
                    $error("FAIL abort_width observed=2+ cycles expected=1 cycle");
                end
            end
        end
        prev_valid = o_rx_valid;
        prev_abort = o_abort;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_sample(input logic [7:0] v);
        i_sample = v;
        i_sample_valid = 1'b1;
        cyc(1);
        i_sample_valid = 1'b0;
    endtask

    // upd_at >= 0 pulses a sample update just before that SCLK cycle;
    // bypass presents byp_val on the exact cycle the CS fall is detected.
    task automatic frame(input int nclk, input logic [31:0] mosi_w, input int upd_at,
                         input logic [7:0] upd_val, input bit bypass,
                         input logic [7:0] byp_val, output logic [31:0] miso_w);
        miso_w = '0;
        i_cs_n = 1'b0;
        if (bypass) begin
            repeat (2) @(posedge i_clk);
            @(negedge i_clk);
            i_sample = byp_val;
            i_sample_valid = 1'b1;
            @(negedge i_clk);
            i_sample_valid = 1'b0;
        end
        cyc(HALF);
        for (int i = 0; i < nclk; i++) begin
            if (i == upd_at) load_sample(upd_val);
            i_spi_mosi = mosi_w[nclk-1-i];
            cyc(HALF);
            i_spi_clk = 1'b1;
            miso_w = {miso_w[30:0], o_spi_miso};
            cyc(HALF);
            i_spi_clk = 1'b0;
        end
        cyc(HALF);
        i_cs_n = 1'b1;
        cyc(HALF + 6);
    endtask

    task automatic good_frame(input logic [15:0] mosi, output logic [31:0] miso_w);
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back('{data: mosi, cnt: exp_cnt});
        frame(16, {16'h0, mosi}, -1, 8'h00, 1'b0, 8'h00, miso_w);
    endtask

    initial begin
        logic [31:0] miso;

        rst = 1'b1;
        cyc(4);
        chk("reset_outputs", {15'h0, o_spi_miso, o_busy, o_rx_valid, o_abort, o_rx_data, o_frame_cnt}, 32'h0);
        rst = 1'b0;
        cyc(6);

        load_sample(8'hA5);
        good_frame(16'h3C7E, miso);
        chk("miso_a5", miso, 32'h0000_14A0);
        chk("sb_drain_1", sb.size(), 0);
        chk("frame_cnt_1", o_frame_cnt, 1);
        chk("rx_3c7e", o_rx_data, 16'h3C7E);

        exp_abort++;
        frame(9, 32'h1FF, -1, 8'h00, 1'b0, 8'h00, miso);
        chk("abort_seen", abort_seen, exp_abort);
        chk("abort_cnt_kept", o_frame_cnt, 1);
        chk("abort_rx_kept", o_rx_data, 16'h3C7E);

        load_sample(8'h12);
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back('{data: 16'hBEEF, cnt: exp_cnt});
        frame(16, 32'hBEEF, 5, 8'hFF, 1'b0, 8'h00, miso);
        chk("miso_inflight_12", miso, 32'h0000_0240);
        good_frame(16'h1234, miso);
        chk("miso_next_ff", miso, 32'h0000_1FE0);

        exp_cnt = exp_cnt + 8'd1;
        sb.push_back('{data: 16'hC001, cnt: exp_cnt});
        frame(16, 32'hC001, -1, 8'h00, 1'b1, 8'h5A, miso);
        chk("miso_bypass_5a", miso, 32'h0000_0B40);

        exp_cnt = exp_cnt + 8'd1;
        sb.push_back('{data: 16'hABCD, cnt: exp_cnt});
        frame(20, 32'h000A_BCDE, -1, 8'h00, 1'b0, 8'h00, miso);
        chk("miso_20clk", miso, 32'h000B_400);
        chk("rx_20clk", o_rx_data, 16'hABCD);
        chk("sb_drain_2", sb.size(), 0);

        while (exp_cnt != 8'd0) begin
            good_frame(16'($urandom), miso);
        end
        chk("frame_cnt_wrap", o_frame_cnt, 0);
        chk("sb_drain_wrap", sb.size(), 0);

        i_cs_n = 1'b0;
        cyc(HALF);
        for (int i = 0; i < 3; i++) begin
            i_spi_clk = 1'b1; cyc(HALF);
            i_spi_clk = 1'b0; cyc(HALF);
        end
        chk("busy_mid_frame", o_busy, 1);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_spi_clk = 1'b1; cyc(HALF);
            i_spi_clk = 1'b0; cyc(HALF);
        end
        cyc(8);
        chk("busy_after_rst_cs_low", o_busy, 0);
        chk("abort_after_rst", abort_seen, exp_abort);
        chk("cnt_after_rst", o_frame_cnt, 0);
        chk("rx_after_rst", o_rx_data, 0);
        i_cs_n = 1'b1;
        cyc(8);
        exp_cnt = 8'd0;
        load_sample(8'h3C);
        good_frame(16'h5AA5, miso);
        chk("miso_after_rst", miso, 32'h0000_0780);
        chk("cnt_after_rst_frame", o_frame_cnt, 1);
        chk("sb_drain_final", sb.size(), 0);
        chk("abort_final", abort_seen, exp_abort);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
